uart_cmd_engine: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 33 +++
 rtl/uart_cmd_engine_if.sv | 11 +
 rtl/uart_cmd_regs.sv | 59 +++++
 rtl/uart_cmd_engine.sv | 145 ++++++++++++++
 tb/tb_uart_cmd_engine.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, status codes, register addresses and parser states for the UART command engine.
package uart_cmd_pkg;

    localparam logic [7:0] SOF_REQ = 8'hA5;
    localparam logic [7:0] SOF_RSP = 8'h5A;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_PING  = 8'h03;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_CHK  = 8'h01;
    localparam logic [7:0] ST_BAD_CMD  = 8'h02;
    localparam logic [7:0] ST_BAD_ADDR = 8'h03;

    localparam logic [7:0] REG_ID      = 8'h00;
    localparam logic [7:0] REG_SCRATCH = 8'h01;
    localparam logic [7:0] REG_CTRL    = 8'h02;
    localparam logic [7:0] REG_CNT_LO  = 8'h03;
    localparam logic [7:0] REG_CNT_HI  = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_D0,
        S_D1,
        S_CHK,
        S_EXEC,
        S_TX
    } state_t;

endpackage

// File: rtl/uart_cmd_engine_if.sv
// Byte stream bundle: receive strobe from the UART RX and valid/ready byte sink toward the UART TX.
interface uart_cmd_engine_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output rx_valid, rx_data, tx_ready, input tx_valid, tx_data);
    modport slave  (input rx_valid, rx_data, tx_ready, output tx_valid, tx_data);
endinterface

// File: rtl/uart_cmd_regs.sv
// Register file for the command engine: ID, scratch, control, free-running counter and its high-half shadow.
module uart_cmd_regs
    import uart_cmd_pkg::*;
#(
    parameter logic [15:0] ID_VALUE = 16'hC301
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        addr_bad,
    output logic        addr_ro
);

    logic [31:0] counter;
    logic [15:0] scratch;
    logic [15:0] hi_shadow;
    logic        cnt_en;
    logic        wr_ok;

    always_comb begin
        addr_bad = (addr > REG_CNT_HI);
        addr_ro  = (addr == REG_ID) || (addr == REG_CNT_LO) || (addr == REG_CNT_HI);
        wr_ok    = wr_en && !addr_bad && !addr_ro;
        unique case (addr)
            REG_ID:      rdata = ID_VALUE;
            REG_SCRATCH: rdata = scratch;
            REG_CTRL:    rdata = {15'h0000, cnt_en};
            REG_CNT_LO:  rdata = counter[15:0];
            REG_CNT_HI:  rdata = hi_shadow;
            default:     rdata = 16'h0000;
        endcase
    end

    // Clear wins over increment; reading the low half snapshots the high half atomically.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter   <= 32'h0;
            scratch   <= 16'h0;
            hi_shadow <= 16'h0;
            cnt_en    <= 1'b1;
        end else begin
            if (wr_ok && addr == REG_CTRL && wdata[1])
                counter <= 32'h0;
            else if (cnt_en)
                counter <= counter + 32'd1;
            if (wr_ok && addr == REG_SCRATCH)
                scratch <= wdata;
            if (wr_ok && addr == REG_CTRL)
                cnt_en <= wdata[0];
            if (rd_en && addr == REG_CNT_LO)
                hi_shadow <= counter[31:16];
        end
    end

endmodule

// File: rtl/uart_cmd_engine.sv
// UART command parser / register-access engine: 6-byte request in, 6-byte response out.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_engine
    import uart_cmd_pkg::*;
#(
    parameter logic [15:0] ID_VALUE       = 16'hC301,
    parameter logic [15:0] PING_VALUE     = 16'hC0DE,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    uart_cmd_engine_if.slave  bus
);

    state_t      state, state_n;
    logic [2:0]  tx_idx;
    logic [7:0]  cmd_q, addr_q, d0_q, d1_q, xor_q;
    logic        chk_ok_q;
    logic [7:0]  rsp_status_q, rsp_d0_q, rsp_d1_q, rsp_chk_q;
    logic [7:0]  status_c;
    logic [15:0] data_c;
    logic        rd_en, wr_en;
    logic [15:0] reg_rdata;
    logic        addr_bad, addr_ro;
    logic        tmo_hit;

    uart_cmd_regs #(.ID_VALUE(ID_VALUE)) u_regs (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .addr     (addr_q),
        .wdata    ({d1_q, d0_q}),
        .rdata    (reg_rdata),
        .addr_bad (addr_bad),
        .addr_ro  (addr_ro)
    );

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_frame;

    assign in_frame = (state == S_CMD) || (state == S_ADDR) || (state == S_D0) ||
                      (state == S_D1) || (state == S_CHK);
    assign tmo_hit  = in_frame && !bus.rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (in_frame && !bus.rx_valid && !tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            tx_idx <= 3'd0;
        end else begin
            state <= state_n;
            if (state == S_EXEC)
                tx_idx <= 3'd0;
            else if (state == S_TX && bus.tx_ready)
                tx_idx <= (tx_idx == 3'd5) ? 3'd0 : tx_idx + 3'd1;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (bus.rx_valid && bus.rx_data == SOF_REQ) state_n = S_CMD;
            S_CMD:  if (bus.rx_valid) state_n = S_ADDR; else if (tmo_hit) state_n = S_IDLE;
            S_ADDR: if (bus.rx_valid) state_n = S_D0;   else if (tmo_hit) state_n = S_IDLE;
            S_D0:   if (bus.rx_valid) state_n = S_D1;   else if (tmo_hit) state_n = S_IDLE;
            S_D1:   if (bus.rx_valid) state_n = S_CHK;  else if (tmo_hit) state_n = S_IDLE;
            S_CHK:  if (bus.rx_valid) state_n = S_EXEC; else if (tmo_hit) state_n = S_IDLE;
            S_EXEC: state_n = S_TX;
            S_TX:   if (bus.tx_ready && tx_idx == 3'd5) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Command decode during EXEC: checksum first, then opcode, then register legality.
    always_comb begin
        status_c = ST_OK;
        data_c   = 16'h0000;
        rd_en    = (state == S_EXEC) && chk_ok_q && (cmd_q == CMD_READ);
        wr_en    = (state == S_EXEC) && chk_ok_q && (cmd_q == CMD_WRITE);
        if (!chk_ok_q) begin
            status_c = ST_BAD_CHK;
        end else begin
            unique case (cmd_q)
                CMD_PING:  data_c = PING_VALUE;
                CMD_READ:  if (addr_bad) status_c = ST_BAD_ADDR; else data_c = reg_rdata;
                CMD_WRITE: if (addr_bad || addr_ro) status_c = ST_BAD_ADDR; else data_c = {d1_q, d0_q};
                default:   status_c = ST_BAD_CMD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (bus.rx_valid) begin
            unique case (state)
                S_IDLE: xor_q <= bus.rx_data;
                S_CMD:  begin cmd_q  <= bus.rx_data; xor_q <= xor_q ^ bus.rx_data; end
                S_ADDR: begin addr_q <= bus.rx_data; xor_q <= xor_q ^ bus.rx_data; end
                S_D0:   begin d0_q   <= bus.rx_data; xor_q <= xor_q ^ bus.rx_data; end
                S_D1:   begin d1_q   <= bus.rx_data; xor_q <= xor_q ^ bus.rx_data; end
                S_CHK:  chk_ok_q <= (xor_q == bus.rx_data);
                default: ;
            endcase
        end
        if (state == S_EXEC) begin
            rsp_status_q <= status_c;
            rsp_d0_q     <= data_c[7:0];
            rsp_d1_q     <= data_c[15:8];
            rsp_chk_q    <= SOF_RSP ^ status_c ^ addr_q ^ data_c[7:0] ^ data_c[15:8];
        end
    end

    assign bus.tx_valid = (state == S_TX);

    always_comb begin
        bus.tx_data = 8'h00;
        if (state == S_TX) begin
            unique case (tx_idx)
                3'd0:    bus.tx_data = SOF_RSP;
                3'd1:    bus.tx_data = rsp_status_q;
                3'd2:    bus.tx_data = addr_q;
                3'd3:    bus.tx_data = rsp_d0_q;
                3'd4:    bus.tx_data = rsp_d1_q;
                3'd5:    bus.tx_data = rsp_chk_q;
                default: bus.tx_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed self-checking bench for uart_cmd_engine: PING, register access, errors, back-pressure, counter.
module tb_uart_cmd_engine;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [7:0]  rsp [6];
    logic [15:0] v1, v2;

    uart_cmd_engine_if bus();

    uart_cmd_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_raw(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [7:0] d0, input logic [7:0] d1, input bit bad_chk);
        logic [7:0] f [6];
        f[0] = 8'hA5; f[1] = cmd; f[2] = addr; f[3] = d0; f[4] = d1;
        f[5] = bad_chk ? 8'h00 : (f[0] ^ f[1] ^ f[2] ^ f[3] ^ f[4]);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = f[i];
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic recv(input int stall_at);
        int         got    = 0;
        int         stalls = 0;
        int         cyc    = 0;
        logic [7:0] held   = 8'h00;
        bit         stable = 1'b1;
        while (got < 6 && cyc < 300) begin
            if (got == stall_at && stalls < 10) begin
                bus.tx_ready = 1'b0;
                if (stalls == 0) held = bus.tx_data;
                else if (bus.tx_data !== held || bus.tx_valid !== 1'b1) stable = 1'b0;
                stalls++;
            end else begin
                bus.tx_ready = 1'b1;
            end
            if (bus.tx_valid && bus.tx_ready) begin
                rsp[got] = bus.tx_data;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.tx_ready = 1'b1;
        chk("rsp_byte_count", got, 6);
        if (stall_at >= 0) chk("stall_stable", stable, 1);
        chk("tx_idle_after", bus.tx_valid, 0);
    endtask

    task automatic do_cmd(input logic [7:0] cmd, input logic [7:0] addr,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input bit bad_chk, input int stall_at);
        send_frame(cmd, addr, d0, d1, bad_chk);
        recv(stall_at);
    endtask

    task automatic check_rsp(input string tag, input logic [7:0] st, input logic [7:0] addr,
                             input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] e [6];
        e[0] = 8'h5A; e[1] = st; e[2] = addr; e[3] = d0; e[4] = d1;
        e[5] = e[0] ^ e[1] ^ e[2] ^ e[3] ^ e[4];
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s[%0d]", tag, i), rsp[i], e[i]);
    endtask

    initial begin
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx_valid", bus.tx_valid, 0);
        chk("reset_tx_data", bus.tx_data, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // PING with latency: EXEC one cycle after CHK, tx_valid the cycle after that
        send_frame(8'h03, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("ping_lat_exec", bus.tx_valid, 0);
        @(negedge clk);
        chk("ping_lat_tx", bus.tx_valid, 1);
        recv(-1);
        check_rsp("ping", 8'h00, 8'h00, 8'hDE, 8'hC0);

        do_cmd(8'h02, 8'h00, 8'h00, 8'h00, 1'b0, -1);
        check_rsp("rd_id", 8'h00, 8'h00, 8'h01, 8'hC3);

        do_cmd(8'h02, 8'h03, 8'h00, 8'h00, 1'b0, -1);
        chk("cnt1_status", rsp[1], 8'h00);
        v1 = {rsp[4], rsp[3]};
        repeat (150) @(negedge clk);
        do_cmd(8'h02, 8'h03, 8'h00, 8'h00, 1'b0, -1);
        chk("cnt2_status", rsp[1], 8'h00);
        v2 = {rsp[4], rsp[3]};
        chk("cnt_delta_min", ((v2 - v1) >= 16'd150), 1);
        chk("cnt_delta_max", ((v2 - v1) < 16'd220), 1);
        do_cmd(8'h02, 8'h04, 8'h00, 8'h00, 1'b0, -1);
        check_rsp("rd_hi", 8'h00, 8'h04, 8'h00, 8'h00);

        do_cmd(8'h01, 8'h01, 8'h34, 8'h12, 1'b0, -1);
        check_rsp("wr_scratch", 8'h00, 8'h01, 8'h34, 8'h12);
        do_cmd(8'h02, 8'h01, 8'h00, 8'h00, 1'b0, -1);
        check_rsp("rd_scratch", 8'h00, 8'h01, 8'h34, 8'h12);

        do_cmd(8'h03, 8'h00, 8'h00, 8'h00, 1'b1, -1);
        check_rsp("bad_chk", 8'h01, 8'h00, 8'h00, 8'h00);
        do_cmd(8'h07, 8'h01, 8'h55, 8'h66, 1'b0, -1);
        check_rsp("bad_cmd", 8'h02, 8'h01, 8'h00, 8'h00);
        do_cmd(8'h02, 8'h09, 8'h00, 8'h00, 1'b0, -1);
        check_rsp("bad_addr_rd", 8'h03, 8'h09, 8'h00, 8'h00);
        do_cmd(8'h01, 8'h03, 8'hAA, 8'hBB, 1'b0, -1);
        check_rsp("ro_wr_lo", 8'h03, 8'h03, 8'h00, 8'h00);
        do_cmd(8'h01, 8'h00, 8'hAA, 8'hBB, 1'b0, -1);
        check_rsp("ro_wr_id", 8'h03, 8'h00, 8'h00, 8'h00);
        do_cmd(8'h02, 8'h01, 8'h00, 8'h00, 1'b0, -1);
        check_rsp("scratch_kept", 8'h00, 8'h01, 8'h34, 8'h12);

        do_cmd(8'h02, 8'h01, 8'h00, 8'h00, 1'b0, 3);
        check_rsp("stall", 8'h00, 8'h01, 8'h34, 8'h12);

        send_raw(8'h00);
        send_raw(8'hFF);
        do_cmd(8'h03, 8'h42, 8'h11, 8'h22, 1'b0, -1);
        check_rsp("garbage_ping", 8'h00, 8'h42, 8'hDE, 8'hC0);

        // Reset mid-frame must discard the partial frame
        send_raw(8'hA5);
        send_raw(8'h02);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_cmd(8'h03, 8'h07, 8'h00, 8'h00, 1'b0, -1);
        check_rsp("post_reset_ping", 8'h00, 8'h07, 8'hDE, 8'hC0);
        do_cmd(8'h02, 8'h01, 8'h00, 8'h00, 1'b0, -1);
        check_rsp("scratch_after_rst", 8'h00, 8'h01, 8'h00, 8'h00);

        do_cmd(8'h01, 8'h02, 8'h02, 8'h00, 1'b0, -1);
        check_rsp("ctrl_clr", 8'h00, 8'h02, 8'h02, 8'h00);
        do_cmd(8'h02, 8'h03, 8'h00, 8'h00, 1'b0, -1);
        check_rsp("cnt_cleared", 8'h00, 8'h03, 8'h00, 8'h00);
        do_cmd(8'h02, 8'h02, 8'h00, 8'h00, 1'b0, -1);
        check_rsp("ctrl_rd", 8'h00, 8'h02, 8'h00, 8'h00);
        do_cmd(8'h01, 8'h02, 8'h01, 8'h00, 1'b0, -1);
        check_rsp("ctrl_en", 8'h00, 8'h02, 8'h01, 8'h00);
        do_cmd(8'h02, 8'h03, 8'h00, 8'h00, 1'b0, -1);
        chk("cnt_restart_status", rsp[1], 8'h00);
        v1 = {rsp[4], rsp[3]};
        chk("cnt_restart_small", (v1 > 16'd0) && (v1 < 16'd100), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
